count_gate_sequencer: RTL and testbench

COUNT_GATE_SEQUENCER -- requirements
Module: count_gate_sequencer

---
 rtl/count_gate_sequencer.sv | 163 ++++++++++++++++
 tb/tb_count_gate_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_gate_sequencer.sv
// count_gate_sequencer
//
// Opens a counting gate for a programmed number of clock cycles, then
// captures the external counter value. It repeats this for a programmed
// number of windows, or runs continuously until aborted. Captured results
// go to a single-entry valid/ready output buffer. If a result arrives while
// the previous one is still unclaimed, the new result is dropped and a
// sticky overflow flag is raised.
//
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous, active-high reset
//   i_trigger   start request (level, sampled in IDLE only)
//   i_stop      abort: ends the current window early, then returns to IDLE
//   i_gate_len  window length in cycles (latched at start; 0 = ignore start)
//   i_repeat    windows per run (latched at start; 0 = continuous)
//   o_gate      registered gate to the downstream counter
//   i_count     running count from the downstream counter
//   o_data      captured window count
//   o_idx       0-based window index of o_data within its run
//   o_partial   the window in o_data was cut short by i_stop
//   o_valid     result valid
//   i_ready     consumer ready; a transfer happens when o_valid & i_ready
//   o_busy      high whenever the FSM is not IDLE
//   o_overflow  sticky: a result was dropped (cleared at the next start)
module count_gate_sequencer #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_trigger,
  input  logic             i_stop,
  input  logic [LEN_W-1:0] i_gate_len,
  input  logic [IDX_W-1:0] i_repeat,
  output logic             o_gate,
  input  logic [CNT_W-1:0] i_count,
  output logic [CNT_W-1:0] o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_partial,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;      // window length reloaded for each window
  logic [LEN_W-1:0] remain_q;   // gate cycles left in the current window
  logic [IDX_W-1:0] rep_q;      // windows per run, 0 = continuous
  logic [IDX_W-1:0] idx_q;      // index of the window being gated
  logic             partial_q;  // current window was aborted by i_stop

  logic [IDX_W-1:0] idx_next;
  logic             last_win;
  logic             start;
  logic             load;

  always_comb begin
    state_d  = state_q;
    idx_next = idx_q + IDX_W'(1);
    last_win = (rep_q != '0) && (idx_next == rep_q);
    start    = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_trigger && (i_gate_len != '0)) begin
          start   = 1'b1;
          state_d = GATE;
        end
      end
      GATE: begin
        // remain_q == 1 marks the last gate cycle of a full-length window.
        if (i_stop || (remain_q == LEN_W'(1))) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        load = !o_valid || i_ready;
        if (partial_q || i_stop || last_win) begin
          state_d = IDLE;
        end else begin
          state_d = GATE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      remain_q   <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      partial_q  <= 1'b0;
      o_gate     <= 1'b0;
      o_busy     <= 1'b0;
      o_data     <= '0;
      o_idx      <= '0;
      o_partial  <= 1'b0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      // Gate and busy are registered from the next state, so they line up
      // exactly with the state they describe.
      o_gate  <= (state_d == GATE);
      o_busy  <= (state_d != IDLE);

      // A transfer empties the buffer; a capture below may refill it in
      // the same cycle, and its assignment takes precedence.
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= i_gate_len;
            remain_q   <= i_gate_len;
            rep_q      <= i_repeat;
            idx_q      <= '0;
            partial_q  <= 1'b0;
            o_overflow <= 1'b0;
          end
        end
        GATE: begin
          remain_q <= remain_q - LEN_W'(1);
          if (i_stop) begin
            partial_q <= 1'b1;
          end
        end
        CAPTURE: begin
          // i_count is sampled at the closing edge of CAPTURE, after the
          // counter's last in-window increment has settled.
          if (load) begin
            o_data    <= i_count;
            o_idx     <= idx_q;
            o_partial <= partial_q;
            o_valid   <= 1'b1;
          end else begin
            o_overflow <= 1'b1;
          end
          if (state_d == GATE) begin
            idx_q    <= idx_next;
            remain_q <= len_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_gate_sequencer.sv
module tb_count_gate_sequencer;

  localparam int CNT_W = 32;
  localparam int LEN_W = 32;
  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig;
  logic             stop;
  logic [LEN_W-1:0] gl;
  logic [IDX_W-1:0] rp;
  logic             gate;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] data;
  logic [IDX_W-1:0] idx;
  logic             part;
  logic             valid;
  logic             rdy;
  logic             busy;
  logic             ovf;

  always #5 clk = ~clk;

  count_gate_sequencer #(
    .CNT_W(CNT_W),
    .LEN_W(LEN_W),
    .IDX_W(IDX_W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_trigger  (trig),
    .i_stop     (stop),
    .i_gate_len (gl),
    .i_repeat   (rp),
    .o_gate     (gate),
    .i_count    (cnt),
    .o_data     (data),
    .o_idx      (idx),
    .o_partial  (part),
    .o_valid    (valid),
    .i_ready    (rdy),
    .o_busy     (busy),
    .o_overflow (ovf)
  );

  int tests = 0;
  int fails = 0;

  // Event input to the downstream counter for the current cycle.
  bit ev;

  // Reference model: a run is described by its window length, repeat
  // count, the current window number, and the position inside the window.
  // Positions 0..wlen-1 are gate cycles; position wlen is the capture cycle.
  bit              m_run;
  int unsigned     m_len;
  logic [15:0]     m_rep;
  logic [15:0]     m_k;
  int unsigned     m_pos;
  int unsigned     m_wlen;
  bit              m_cut;
  int unsigned     m_sum;    // events counted in the current window
  bit              e_valid;
  logic [31:0]     e_data;
  logic [15:0]     e_idx;
  bit              e_part;
  bit              e_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pv;
    bit fin;
    pv = e_valid;
    if (rst) begin
      m_run = 0; m_pos = 0; m_wlen = 0; m_cut = 0; m_sum = 0;
      e_valid = 0; e_data = '0; e_idx = '0; e_part = 0; e_ovf = 0;
    end else if (!m_run) begin
      if (pv && rdy) e_valid = 0;
      if (trig && gl != 0) begin
        m_run = 1; m_len = gl; m_rep = rp; m_k = '0;
        m_pos = 0; m_wlen = gl; m_cut = 0; m_sum = 0; e_ovf = 0;
      end
    end else if (m_pos < m_wlen) begin
      if (pv && rdy) e_valid = 0;
      if (ev) m_sum++;
      if (stop) begin
        m_cut  = 1;
        m_wlen = m_pos + 1;
      end
      m_pos++;
    end else begin
      if (pv && rdy) e_valid = 0;
      if (!pv || rdy) begin
        e_valid = 1; e_data = m_sum; e_idx = m_k; e_part = m_cut;
      end else begin
        e_ovf = 1;
      end
      fin = m_cut || stop || (m_rep != 0 && (m_k + 16'd1) == m_rep);
      if (fin) begin
        m_run = 0;
      end else begin
        m_k = m_k + 16'd1; m_pos = 0; m_sum = 0; m_wlen = m_len;
      end
    end
  endtask

  // One clock: inputs are already set; update the external counter from
  // the gate level seen before the edge, advance the model, compare.
  task automatic step();
    logic gp;
    gp = gate;
    @(posedge clk);
    #1;
    if (gp === 1'b1) cnt = cnt + (ev ? 32'd1 : 32'd0);
    else             cnt = '0;
    model_edge();
    chk("gate",     64'(gate),  64'(m_run && m_pos < m_wlen));
    chk("busy",     64'(busy),  64'(m_run));
    chk("valid",    64'(valid), 64'(e_valid));
    chk("overflow", 64'(ovf),   64'(e_ovf));
    chk("data",     64'(data),  64'(e_data));
    chk("idx",      64'(idx),   64'(e_idx));
    chk("partial",  64'(part),  64'(e_part));
  endtask

  task automatic quiet();
    trig = 0; stop = 0; rst = 0; ev = 0;
  endtask

  initial begin
    rst = 1; trig = 0; stop = 0; gl = '0; rp = '0; rdy = 1; ev = 0; cnt = '0;
    step(); step();
    quiet();
    step();

    // Single window of 5 cycles, three counted events.
    gl = 5; rp = 1; rdy = 1; trig = 1;
    step();
    trig = 0;
    for (int i = 1; i < 10; i++) begin
      ev = (i == 1 || i == 2 || i == 4);
      step();
    end
    ev = 0;
    chk("req033_data", 64'(data), 64'd3);
    chk("req033_busy", 64'(busy), 64'd0);

    // Three windows of 4 with a ready consumer.
    gl = 4; rp = 3; trig = 1;
    step();
    trig = 0;
    for (int i = 0; i < 20; i++) begin
      ev = $urandom_range(1, 0) == 1;
      step();
    end
    chk("req034_idx", 64'(idx), 64'd2);
    chk("req034_ovf", 64'(ovf), 64'd0);

    // Continuous run of 10-cycle windows aborted at the 4th gate cycle.
    gl = 10; rp = 0; trig = 1;
    step();
    trig = 0;
    for (int i = 1; i < 20; i++) begin
      stop = (i == 4);
      ev = $urandom_range(1, 0) == 1;
      step();
    end
    stop = 0;
    chk("req035_partial", 64'(part), 64'd1);
    chk("req035_busy",    64'(busy), 64'd0);

    // Stalled consumer: first result held, later ones dropped.
    rdy = 0; gl = 2; rp = 3; trig = 1;
    step();
    trig = 0;
    for (int i = 0; i < 12; i++) begin
      ev = $urandom_range(1, 0) == 1;
      step();
    end
    chk("req036_idx", 64'(idx), 64'd0);
    chk("req036_ovf", 64'(ovf), 64'd1);

    // New trigger clears overflow; reset mid-gate with a result pending.
    gl = 8; rp = 1; trig = 1;
    step();
    trig = 0;
    step(); step(); step();
    rst = 1;
    step();
    rst = 0;
    chk("req037_valid", 64'(valid), 64'd0);
    gl = 0; trig = 1;
    for (int i = 0; i < 4; i++) step();
    trig = 0;
    chk("req037_busy", 64'(busy), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(199, 0) == 0);
      trig = ($urandom_range(9, 0) == 0);
      stop = ($urandom_range(29, 0) == 0);
      gl   = LEN_W'($urandom_range(6, 0));
      rp   = IDX_W'($urandom_range(3, 0));
      rdy  = ($urandom_range(9, 0) < 6);
      ev   = ($urandom_range(1, 0) == 1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
